// File: rtl/demux3_pkg.sv
// rtl/demux3_pkg.sv - shared types and constants for the 3-way buffered demux
package demux3_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {CH0 = 2'd0, CH1 = 2'd1, CH2 = 2'd2} ch_e;

  // Both upper select codes land on the last channel.
  function automatic ch_e sel_to_ch(input logic [1:0] sel);
    case (sel)
      2'b00:   return CH0;
      2'b01:   return CH1;
      default: return CH2;
    endcase
  endfunction

endpackage

// File: rtl/demux3_buf_fifo2.sv
// rtl/demux3_buf_fifo2.sv - two-entry ring-buffer FIFO used per output channel
import demux3_pkg::*;

module fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Simultaneous push/pop at count 1 moves the head onto the slot just written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'(FIFO_DEPTH));

endmodule

// File: rtl/demux3_buf.sv
// rtl/demux3_buf.sv - routes one input stream into three independently buffered channels
import demux3_pkg::*;

module demux3_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  output logic [7:0]       acc_cnt
);

  ch_e              ch;
  logic             accept;
  logic             full0, full1, full2;
  logic             empty0, empty1, empty2;
  logic [CNT_W-1:0] acc_q;

  assign ch = sel_to_ch(s);

  // Readiness looks only at the selected channel's fullness, never at pops.
  always_comb begin
    in_ready = 1'b0;
    case (ch)
      CH0:     in_ready = ~full0;
      CH1:     in_ready = ~full1;
      default: in_ready = ~full2;
    endcase
  end

  assign accept = in_valid & in_ready;

  fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk(clk), .reset_n(reset_n),
    .push(accept && ch == CH0), .pop(r0),
    .din(d), .dout(y0), .empty(empty0), .full(full0)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk(clk), .reset_n(reset_n),
    .push(accept && ch == CH1), .pop(r1),
    .din(d), .dout(y1), .empty(empty1), .full(full1)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo2 (
    .clk(clk), .reset_n(reset_n),
    .push(accept && ch == CH2), .pop(r2),
    .din(d), .dout(y2), .empty(empty2), .full(full2)
  );

  assign v0 = ~empty0;
  assign v1 = ~empty1;
  assign v2 = ~empty2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else if (accept) acc_q <= acc_q + 1'b1;
  end

  assign acc_cnt = acc_q;

endmodule

// File: tb/tb_demux3_buf.sv
// tb/tb_demux3_buf.sv - scoreboard bench for demux3_buf
module tb_demux3_buf;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d = '0;
  logic [1:0] s = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y0, y1, y2;
  logic       v0, v1, v2;
  logic       r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  logic [7:0] acc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] acc_m = '0;

  demux3_buf #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .y0(y0), .y1(y1), .y2(y2),
    .v0(v0), .v1(v1), .v2(v2), .r0(r0), .r1(r1), .r2(r2),
    .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic clear_model();
    q0.delete();
    q1.delete();
    q2.delete();
    acc_m = '0;
  endtask

  // Checks outputs mid-cycle, then advances the model by what the next edge does.
  task automatic cycle();
    int  k;
    bit  rdy;
    @(negedge clk);
    k = (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : 2;
    check("acc_cnt", acc_cnt, acc_m);
    check("v0", v0, q0.size() > 0);
    check("v1", v1, q1.size() > 0);
    check("v2", v2, q2.size() > 0);
    if (q0.size() > 0) check("y0", y0, q0[0]);
    if (q1.size() > 0) check("y1", y1, q1[0]);
    if (q2.size() > 0) check("y2", y2, q2[0]);
    rdy = qsize(k) < 2;
    check("in_ready", in_ready, rdy);
    if (r0 && q0.size() > 0) void'(q0.pop_front());
    if (r1 && q1.size() > 0) void'(q1.pop_front());
    if (r2 && q2.size() > 0) void'(q2.pop_front());
    if (in_valid && rdy) begin
      case (k)
        0:       q0.push_back(d);
        1:       q1.push_back(d);
        default: q2.push_back(d);
      endcase
      acc_m = acc_m + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit vld, input logic [1:0] sel, input logic [7:0] data,
                       input bit p0, input bit p1, input bit p2);
    in_valid = vld; s = sel; d = data; r0 = p0; r1 = p1; r2 = p2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    reset_n = 1'b1;
  endtask

  initial begin
    #1;
    check("rst_v0", v0, 0);
    check("rst_v1", v1, 0);
    check("rst_v2", v2, 0);
    check("rst_y0", y0, 0);
    check("rst_y1", y1, 0);
    check("rst_y2", y2, 0);
    check("rst_acc", acc_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // single word to ch1
    drive(1, 2'b01, 8'hA5, 0, 0, 0);
    cycle();
    check("t028_v1", v1, 1);
    check("t028_y1", y1, 8'hA5);
    check("t028_v0", v0, 0);
    check("t028_v2", v2, 0);
    check("t028_acc", acc_cnt, 1);
    drive(0, 2'b01, 8'h00, 0, 1, 0);
    cycle();

    // fill ch2 via s=11, then readiness per select
    drive(1, 2'b11, 8'h11, 0, 0, 0);
    cycle();
    drive(1, 2'b11, 8'h22, 0, 0, 0);
    cycle();
    drive(0, 2'b11, 8'h00, 0, 0, 0);
    #1;
    check("t029_rdy_full", in_ready, 0);
    s = 2'b00;
    #1;
    check("t029_rdy_ch0", in_ready, 1);
    check("t029_y2", y2, 8'h11);

    // full ch2: pop and push on the same edge, push refused
    drive(1, 2'b11, 8'h33, 0, 0, 1);
    #1;
    check("t030_rdy", in_ready, 0);
    cycle();
    check("t030_y2", y2, 8'h22);
    check("t030_v2", v2, 1);
    drive(1, 2'b11, 8'h33, 0, 0, 0);
    cycle();
    check("t030_acc", acc_cnt, 4);
    drive(0, 2'b00, 8'h00, 0, 0, 1);
    cycle();
    check("t030_y2_33", y2, 8'h33);
    cycle();
    check("t030_drained", v2, 0);

    // ch0 at count 1: push and pop together leave the new word at head
    drive(1, 2'b00, 8'h44, 0, 0, 0);
    cycle();
    drive(1, 2'b00, 8'h55, 1, 0, 0);
    cycle();
    check("t031_v0", v0, 1);
    check("t031_y0", y0, 8'h55);
    drive(0, 2'b00, 8'h00, 1, 0, 0);
    cycle();

    // 256 round-robin words with all consumers ready
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'(i % 3), 8'(i * 7 + 3), 1, 1, 1);
      cycle();
    end
    check("t032_acc_wrap", acc_cnt, 0);
    drive(0, 2'b00, 8'h00, 1, 1, 1);
    cycle();

    // asynchronous reset with every channel holding data
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'(i), 8'hC0 + 8'(i), 0, 0, 0);
      cycle();
    end
    check("t033_pre_acc", acc_cnt, 3);
    drive(0, 2'b00, 8'h00, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    check("t033_v0", v0, 0);
    check("t033_v1", v1, 0);
    check("t033_v2", v2, 0);
    check("t033_y2", y2, 0);
    check("t033_acc", acc_cnt, 0);
    check("t033_rdy", in_ready, 1);
    clear_model();
    #1;
    reset_n = 1'b1;
    cycle();

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
